// File: rtl/pc_pkg.sv
// Shared types and defaults for the SESO program-counter / fetch sequencer.
// Optional bounds checking is enabled by defining PC_BOUNDS_CHECK_EN.
package pc_pkg;

   localparam int PC_W       = 10;
   localparam int PROG_DEPTH = 1024;
   localparam int CNT_W      = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE,
      FAULT
   } pc_state_t;

   typedef logic signed [PC_W-1:0] pc_off_t;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC adder: +1 step or sign-extended branch offset, plus a flag
// raised when the true sum leaves 0..PROG_DEPTH-1 or wraps the PC width.
module pc_next_calc
   import pc_pkg::*;
#(
   parameter int PC_W       = pc_pkg::PC_W,
   parameter int PROG_DEPTH = pc_pkg::PROG_DEPTH
) (
   input  logic [PC_W-1:0] pc_i,
   input  logic [PC_W-1:0] target_i,
   input  logic            take_branch_i,
   output logic [PC_W-1:0] next_pc_o,
   output logic            oob_o
);

   logic signed [31:0] pc_ext;
   logic signed [31:0] off_ext;
   logic signed [31:0] sum;

   // Sum is formed wide so that wrap and range are judged on the true value
   always_comb begin
      pc_ext    = 32'(pc_i);
      off_ext   = take_branch_i ? 32'(signed'(target_i))
                                : 32'sd1;
      sum       = pc_ext + off_ext;
      next_pc_o = sum[PC_W-1:0];
      oob_o     = (sum < 0)
               || (sum >= PROG_DEPTH)
               || (sum >= (1 <<< PC_W));
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// SESO PC and fetch sequencer: run/halt FSM, Start edge detect, retire count.
// Define PC_BOUNDS_CHECK_EN to trap out-of-range or wrapping PC updates.
module pc_fetch_ctrl
   import pc_pkg::*;
#(
   parameter int PC_W       = pc_pkg::PC_W,
   parameter int PROG_DEPTH = pc_pkg::PROG_DEPTH,
   parameter int CNT_W      = pc_pkg::CNT_W
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic             Stall,
   input  logic             Halt,
   input  logic             BranchEn,
   input  logic             BranchTkn,
   input  logic [3:0]       BranchSel,
   output logic [3:0]       LutAddr,
   input  logic [PC_W-1:0]  Target,
   output logic [PC_W-1:0]  PC,
   output logic             Running,
   output logic             Done,
   output logic [CNT_W-1:0] InstrCnt,
   output logic             Fault
);

   pc_state_t        state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             start_q;

   logic             start_rise;
   logic             take_branch;
   logic             advance;
   logic [PC_W-1:0]  next_pc;
   logic             oob;
   logic             bound_fault;

   assign start_rise  = Start & ~start_q;
   assign take_branch = BranchEn & BranchTkn;
   assign advance     = (state_q == RUN) & ~Stall;
   assign LutAddr     = BranchSel;

   pc_next_calc #(
      .PC_W       (PC_W),
      .PROG_DEPTH (PROG_DEPTH)
   ) u_next (
      .pc_i          (pc_q),
      .target_i      (Target),
      .take_branch_i (take_branch),
      .next_pc_o     (next_pc),
      .oob_o         (oob)
   );

`ifdef PC_BOUNDS_CHECK_EN
   assign bound_fault = oob;
`else
   logic unused_oob;
   assign unused_oob  = oob;
   assign bound_fault = 1'b0;
`endif

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         pc_q    <= '0;
         cnt_q   <= '0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         start_q <= Start;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE, FAULT: begin
            if (start_rise)
               state_d = RUN;
         end
         RUN: begin
            if (!Stall) begin
               if (Halt)
                  state_d = DONE;
               else if (bound_fault)
                  state_d = FAULT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Halt retires without moving PC; a trapped update freezes PC at its source
   always_comb begin
      pc_d  = pc_q;
      cnt_d = cnt_q;
      unique case (1'b1)
         (state_q != RUN) && start_rise: begin
            pc_d  = '0;
            cnt_d = '0;
         end
         advance: begin
            cnt_d = (cnt_q == '1) ? cnt_q
                                  : cnt_q + 1'b1;
            if (!Halt && !bound_fault)
               pc_d = next_pc;
         end
         default: ;
      endcase
   end

   always_comb begin
      PC       = pc_q;
      InstrCnt = cnt_q;
      Running  = (state_q == RUN);
      Done     = (state_q == DONE)
              || (state_q == FAULT);
      Fault    = (state_q == FAULT);
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl against a cycle-level reference
// model of the run/halt rules; default build (bounds check compiled out).
module tb_pc_fetch_ctrl;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        Start;
   logic        Stall;
   logic        Halt;
   logic        BranchEn;
   logic        BranchTkn;
   logic [3:0]  BranchSel;
   logic [3:0]  LutAddr;
   logic [9:0]  Target;
   logic [9:0]  PC;
   logic        Running;
   logic        Done;
   logic [15:0] InstrCnt;
   logic        Fault;

   int errors = 0;
   int checks = 0;

   int lut [16];

   int m_pc;
   int m_cnt;
   bit m_run;
   bit m_done;
   bit m_sprev;

   pc_fetch_ctrl dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .Start     (Start),
      .Stall     (Stall),
      .Halt      (Halt),
      .BranchEn  (BranchEn),
      .BranchTkn (BranchTkn),
      .BranchSel (BranchSel),
      .LutAddr   (LutAddr),
      .Target    (Target),
      .PC        (PC),
      .Running   (Running),
      .Done      (Done),
      .InstrCnt  (InstrCnt),
      .Fault     (Fault)
   );

   always #5 Clk = ~Clk;

   always_comb Target = 10'(lut[LutAddr]);

   task automatic model_reset();
      m_pc    = 0;
      m_cnt   = 0;
      m_run   = 0;
      m_done  = 0;
      m_sprev = 0;
   endtask

   task automatic quiet();
      Stall     = 0;
      Halt      = 0;
      BranchEn  = 0;
      BranchTkn = 0;
      BranchSel = 0;
   endtask

   // One rising edge; model applies the program-level rules to the inputs
   task automatic tick();
      @(posedge Clk);
      if (!m_run) begin
         if (Start && !m_sprev) begin
            m_run  = 1;
            m_done = 0;
            m_pc   = 0;
            m_cnt  = 0;
         end
      end else if (!Stall) begin
         if (m_cnt < 65535) m_cnt++;
         if (Halt) begin
            m_run  = 0;
            m_done = 1;
         end else if (BranchEn && BranchTkn) begin
            m_pc = (m_pc + lut[BranchSel] + 1024) % 1024;
         end else begin
            m_pc = (m_pc + 1) % 1024;
         end
      end
      m_sprev = Start;
      #1;
   endtask

   task automatic launch();
      Start = 0;
      tick();
      Start = 1;
      tick();
      Start = 0;
   endtask

   task automatic finish_run();
      Halt = 1;
      tick();
      Halt = 0;
   endtask

   task automatic test_reset();
      Reset_n = 0;
      Start   = 0;
      quiet();
      for (int i = 0; i < 16; i++) lut[i] = 0;
      model_reset();
      #1;
      checks++;
      if (PC !== 10'd0 || Running !== 1'b0 || Done !== 1'b0
          || InstrCnt !== 16'd0 || Fault !== 1'b0) begin
         errors++;
         $display("FAIL reset_init: pc=%0d run=%b done=%b cnt=%0d flt=%b want 0",
                  PC, Running, Done, InstrCnt, Fault);
      end
      #2 Reset_n = 1;
      launch();
      repeat (37) tick();
      checks++;
      if (PC !== 10'(m_pc) || m_pc != 37) begin
         errors++;
         $display("FAIL reset_pre37: pc=%0d want 37", PC);
      end
      #2 Reset_n = 0;
      #1;
      checks++;
      if (PC !== 10'd0 || Running !== 1'b0 || Done !== 1'b0
          || InstrCnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_async: pc=%0d run=%b done=%b cnt=%0d want 0",
                  PC, Running, Done, InstrCnt);
      end
      model_reset();
      #2 Reset_n = 1;
   endtask

   task automatic test_halt_seq();
      launch();
      checks++;
      if (PC !== 10'd0 || InstrCnt !== 16'd0 || Running !== 1'b1) begin
         errors++;
         $display("FAIL launch: pc=%0d cnt=%0d run=%b want 0 0 1",
                  PC, InstrCnt, Running);
      end
      for (int i = 1; i <= 5; i++) begin
         tick();
         checks++;
         if (PC !== 10'(i)) begin
            errors++;
            $display("FAIL step_pc: pc=%0d want %0d", PC, i);
         end
      end
      finish_run();
      checks++;
      if (Done !== 1'b1 || PC !== 10'd5 || InstrCnt !== 16'd6
          || Running !== 1'b0) begin
         errors++;
         $display("FAIL halt: done=%b pc=%0d cnt=%0d run=%b want 1 5 6 0",
                  Done, PC, InstrCnt, Running);
      end
   endtask

   task automatic test_branch();
      lut[1] = -278;
      lut[2] = 300;
      lut[3] = 278;
      launch();
      BranchEn  = 1;
      BranchTkn = 1;
      BranchSel = 2;
      tick();
      checks++;
      if (PC !== 10'd300) begin
         errors++;
         $display("FAIL br_to300: pc=%0d want 300", PC);
      end
      BranchSel = 1;
      #1;
      checks++;
      if (LutAddr !== 4'd1) begin
         errors++;
         $display("FAIL lutaddr: got %0d want 1", LutAddr);
      end
      tick();
      checks++;
      if (PC !== 10'd22) begin
         errors++;
         $display("FAIL br_neg: pc=%0d want 22", PC);
      end
      BranchSel = 3;
      tick();
      BranchTkn = 0;
      tick();
      checks++;
      if (PC !== 10'd301) begin
         errors++;
         $display("FAIL br_nottkn: pc=%0d want 301", PC);
      end
      quiet();
      finish_run();
   endtask

   task automatic test_stall();
      launch();
      repeat (9) tick();
      Stall = 1;
      Halt  = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (PC !== 10'd9 || InstrCnt !== 16'd9 || Running !== 1'b1
             || Done !== 1'b0) begin
            errors++;
            $display("FAIL stall: pc=%0d cnt=%0d run=%b want 9 9 1",
                     PC, InstrCnt, Running);
         end
      end
      Stall = 0;
      tick();
      Halt = 0;
      checks++;
      if (Done !== 1'b1 || PC !== 10'd9 || InstrCnt !== 16'd10) begin
         errors++;
         $display("FAIL stall_rel: done=%b pc=%0d cnt=%0d want 1 9 10",
                  Done, PC, InstrCnt);
      end
   endtask

   task automatic test_wrap();
      lut[4] = -1;
      launch();
      BranchEn  = 1;
      BranchTkn = 1;
      BranchSel = 4;
      tick();
      checks++;
      if (PC !== 10'd1023) begin
         errors++;
         $display("FAIL wrap_neg: pc=%0d want 1023", PC);
      end
      quiet();
      tick();
      checks++;
      if (PC !== 10'd0 || Fault !== 1'b0 || Running !== 1'b1) begin
         errors++;
         $display("FAIL wrap_step: pc=%0d flt=%b run=%b want 0 0 1",
                  PC, Fault, Running);
      end
      finish_run();
      launch();
      checks++;
      if (PC !== 10'd0 || Fault !== 1'b0 || InstrCnt !== 16'd0) begin
         errors++;
         $display("FAIL wrap_relaunch: pc=%0d flt=%b cnt=%0d want 0",
                  PC, Fault, InstrCnt);
      end
      finish_run();
   endtask

   task automatic test_start_hold();
      Start = 0;
      tick();
      Start = 1;
      tick();
      repeat (3) tick();
      Start = 0;
      tick();
      Start = 1;
      tick();
      checks++;
      if (Running !== 1'b1 || PC !== 10'(m_pc) || m_pc != 5) begin
         errors++;
         $display("FAIL start_in_run: run=%b pc=%0d want 1 5", Running, PC);
      end
      finish_run();
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (Running !== 1'b0 || Done !== 1'b1) begin
            errors++;
            $display("FAIL start_held: run=%b done=%b want 0 1",
                     Running, Done);
         end
      end
      Start = 0;
      tick();
      Start = 1;
      tick();
      checks++;
      if (Running !== 1'b1 || Done !== 1'b0 || InstrCnt !== 16'd0
          || PC !== 10'd0) begin
         errors++;
         $display("FAIL relaunch: run=%b done=%b cnt=%0d pc=%0d want 1 0 0 0",
                  Running, Done, InstrCnt, PC);
      end
      Start = 0;
      finish_run();
   endtask

   task automatic test_random();
      for (int i = 0; i < 16; i++)
         lut[i] = int'($urandom_range(0, 1023)) - 512;
      for (int n = 0; n < 400; n++) begin
         Start     = ($urandom_range(0, 15) == 0);
         Stall     = ($urandom_range(0, 3) == 0);
         Halt      = ($urandom_range(0, 29) == 0);
         BranchEn  = ($urandom_range(0, 2) == 0);
         BranchTkn = $urandom_range(0, 1) == 1;
         BranchSel = 4'($urandom_range(0, 15));
         #1;
         checks++;
         if (LutAddr !== BranchSel) begin
            errors++;
            $display("FAIL rnd_lutaddr: got %0d want %0d", LutAddr, BranchSel);
         end
         tick();
         checks++;
         if (PC !== 10'(m_pc) || InstrCnt !== 16'(m_cnt)
             || Running !== m_run || Done !== m_done || Fault !== 1'b0) begin
            errors++;
            $display("FAIL rnd_cyc%0d: pc=%0d/%0d cnt=%0d/%0d run=%b/%b done=%b/%b flt=%b",
                     n, PC, m_pc, InstrCnt, m_cnt, Running, m_run,
                     Done, m_done, Fault);
         end
      end
      quiet();
      Start = 0;
   endtask

   initial begin
      test_reset();
      test_halt_seq();
      test_branch();
      test_stall();
      test_wrap();
      test_start_hold();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
